// File: rtl/line_drive_sequencer.sv
// line_drive_sequencer
//   Drive controller for the two-motor line follower. One state machine
//   replaces the per-motor combinational decode. On top of line following it
//   handles an obstacle (brake, then back off), a lost line (search with a
//   timeout) and a fault halt.
//
// Ports
//   clk                  system clock
//   rst                  synchronous, active-high reset
//   start                level; leaves IDLE/HALT
//   s1..s4               line sensors, s1 leftmost, 1 = line (asynchronous)
//   prox                 proximity sensor, 0 = obstacle (asynchronous)
//   en_l/in1_l/in2_l     left H-bridge  (FWD 0/1, REV 1/0, BRAKE 1/1 with en=1)
//   en_r/in1_r/in2_r     right H-bridge
//   state                current state code
//   fault                search timeout flag
module line_drive_sequencer #(
   parameter int PWM_BITS       = 8,
   parameter int DUTY_FWD       = 200,
   parameter int DUTY_TURN      = 120,
   parameter int DEBOUNCE       = 4,
   parameter int BRAKE_CYCLES   = 1000,
   parameter int BACKUP_CYCLES  = 2000,
   parameter int SEARCH_TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       s1,
   input  logic       s2,
   input  logic       s3,
   input  logic       s4,
   input  logic       prox,
   output logic       en_l,
   output logic       in1_l,
   output logic       in2_l,
   output logic       en_r,
   output logic       in1_r,
   output logic       in2_r,
   output logic [2:0] state,
   output logic       fault
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FOLLOW = 3'd1;
   localparam logic [2:0] ST_BRAKE  = 3'd2;
   localparam logic [2:0] ST_BACKUP = 3'd3;
   localparam logic [2:0] ST_SEARCH = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   // per-side bridge command
   localparam logic [1:0] DR_BRK = 2'd0;
   localparam logic [1:0] DR_FWD = 2'd1;
   localparam logic [1:0] DR_REV = 2'd2;

   localparam int TMAX = (BRAKE_CYCLES > BACKUP_CYCLES) ?
                         ((BRAKE_CYCLES > SEARCH_TIMEOUT) ? BRAKE_CYCLES : SEARCH_TIMEOUT) :
                         ((BACKUP_CYCLES > SEARCH_TIMEOUT) ? BACKUP_CYCLES : SEARCH_TIMEOUT);
   localparam int TW = $clog2(TMAX + 1);
   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   localparam logic [PWM_BITS-1:0] D_FWD  = PWM_BITS'(DUTY_FWD);
   localparam logic [PWM_BITS-1:0] D_TURN = PWM_BITS'(DUTY_TURN);

   // ---------------- input conditioning ----------------
   logic [3:0] sens_m, sens_s;    // {s4,s3,s2,s1}
   logic       prox_m, prox_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         sens_m <= '0;
         sens_s <= '0;
         prox_m <= 1'b1;
         prox_s <= 1'b1;
      end else begin
         sens_m <= {s4, s3, s2, s1};
         sens_s <= sens_m;
         prox_m <= prox;
         prox_s <= prox_m;
      end
   end

   // Debounced obstacle level: flips only after DEBOUNCE consecutive
   // synchronized samples disagree with it; any agreeing sample restarts.
   logic          obst;
   logic [DW-1:0] db_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         obst   <= 1'b0;
         db_cnt <= '0;
      end else if (~prox_s != obst) begin
         if (db_cnt == DW'(DEBOUNCE - 1)) begin
            obst   <= ~obst;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end else begin
         db_cnt <= '0;
      end
   end

   // ---------------- PWM ----------------
   logic [PWM_BITS-1:0] pwm_cnt;

   always_ff @(posedge clk) begin
      if (rst) pwm_cnt <= '0;
      else     pwm_cnt <= pwm_cnt + 1'b1;
   end

   // ---------------- state machine ----------------
   logic [TW-1:0]       timer, nxt_timer;
   logic [2:0]          nxt_state;
   logic                nxt_fault;
   logic                last_dir, nxt_dir;   // 0 = left, 1 = right
   logic [1:0]          drv_l, drv_r;
   logic [PWM_BITS-1:0] duty;
   logic                line_any, piv_l, piv_r;

   assign line_any = |sens_s;
   assign piv_l    = sens_s[0] & ~sens_s[3];
   assign piv_r    = sens_s[3] & ~sens_s[0];

   always_comb begin
      nxt_state = state;
      nxt_fault = fault;
      nxt_dir   = last_dir;
      // saturating count; every state that times itself clears it on entry
      nxt_timer = (timer == '1) ? timer : timer + 1'b1;

      case (state)
         ST_IDLE:
            if (start) nxt_state = ST_FOLLOW;
         ST_FOLLOW:
            if (obst) begin
               nxt_state = ST_BRAKE;
               nxt_timer = '0;
            end else if (!line_any) begin
               nxt_state = ST_SEARCH;
               nxt_timer = '0;
            end
         ST_BRAKE:
            // hold is never cut short; obstacle only chooses the exit
            if (timer == TW'(BRAKE_CYCLES - 1)) begin
               nxt_state = obst ? ST_BACKUP : ST_FOLLOW;
               nxt_timer = '0;
            end
         ST_BACKUP:
            if (timer == TW'(BACKUP_CYCLES - 1)) nxt_state = ST_FOLLOW;
         ST_SEARCH:
            if (obst) begin
               nxt_state = ST_BRAKE;
               nxt_timer = '0;
            end else if (line_any) begin
               nxt_state = ST_FOLLOW;
            end else if (timer == TW'(SEARCH_TIMEOUT - 1)) begin
               nxt_state = ST_HALT;
               nxt_fault = 1'b1;
            end
         ST_HALT:
            if (start) begin
               nxt_state = ST_FOLLOW;
               nxt_fault = 1'b0;
            end
         default:
            nxt_state = ST_IDLE;
      endcase

      // Bridge command follows the state being entered so the outputs
      // register together with it.
      drv_l = DR_BRK;
      drv_r = DR_BRK;
      duty  = D_TURN;
      case (nxt_state)
         ST_FOLLOW:
            if (piv_l) begin
               drv_r   = DR_FWD;
               nxt_dir = 1'b0;
            end else if (piv_r) begin
               drv_l   = DR_FWD;
               nxt_dir = 1'b1;
            end else begin
               drv_l = DR_FWD;
               drv_r = DR_FWD;
               duty  = D_FWD;
            end
         ST_BACKUP: begin
            drv_l = DR_REV;
            drv_r = DR_REV;
         end
         ST_SEARCH:
            if (last_dir) drv_l = DR_FWD;
            else          drv_r = DR_FWD;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         fault    <= 1'b0;
         timer    <= '0;
         last_dir <= 1'b0;
         en_l     <= 1'b1;
         in1_l    <= 1'b1;
         in2_l    <= 1'b1;
         en_r     <= 1'b1;
         in1_r    <= 1'b1;
         in2_r    <= 1'b1;
      end else begin
         state    <= nxt_state;
         fault    <= nxt_fault;
         timer    <= nxt_timer;
         last_dir <= nxt_dir;
         // in1 is low only for FWD, in2 low only for REV, en forced for BRAKE
         en_l     <= (drv_l == DR_BRK) | (pwm_cnt < duty);
         in1_l    <= (drv_l != DR_FWD);
         in2_l    <= (drv_l != DR_REV);
         en_r     <= (drv_r == DR_BRK) | (pwm_cnt < duty);
         in1_r    <= (drv_r != DR_FWD);
         in2_r    <= (drv_r != DR_REV);
      end
   end

endmodule
